// File: rtl/sa_input_feeder.sv
// Per-lane operand FIFOs feeding a systolic array with diagonal skew: lane i of a side appears i+1 edges after its pop.
// No backpressure: skew pipes always advance; bad writes and empty-lane pops are dropped and raise sticky flags.
module sa_input_feeder #(
  parameter int X  = 3,
  parameter int N  = 4,
  parameter int Y  = 3,
  parameter int DW = 16,
  localparam int MXY = (X > Y) ? X : Y,
  localparam int LW  = (MXY > 1) ? $clog2(MXY) : 1,
  localparam int CW  = $clog2(N + 1)
) (
  input  logic            clk,
  input  logic            sys_rst_n,
  input  logic            i_clear,
  input  logic            i_wr_en,
  input  logic            i_wr_side,
  input  logic [LW-1:0]   i_wr_lane,
  input  logic [DW-1:0]   i_wr_data,
  input  logic            i_westin_rd_en,
  input  logic            i_northin_rd_en,
  output logic [X*DW-1:0] o_west_data,
  output logic [X-1:0]    o_west_vld,
  output logic [Y*DW-1:0] o_north_data,
  output logic [Y-1:0]    o_north_vld,
  output logic            o_ready,
  output logic            o_err_ovf,
  output logic            o_err_udf
);
  localparam int L  = X + Y;
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [LW:0]   XLIM  = X[LW:0];
  localparam logic [LW:0]   YLIM  = Y[LW:0];
  localparam logic [CW-1:0] NFULL = N[CW-1:0];
  localparam logic [PW-1:0] PMAX  = PW'(N - 1);

  logic [L-1:0] w_ovf;
  logic [L-1:0] w_udf;
  logic [L-1:0] w_full_nxt;
  logic         w_oor;
  logic         r_ready;
  logic         r_err_ovf;
  logic         r_err_udf;

  assign w_oor = i_wr_en && (i_wr_side ? ({1'b0, i_wr_lane} >= YLIM)
                                       : ({1'b0, i_wr_lane} >= XLIM));

  // Lanes 0..X-1 are the west bank, X..X+Y-1 the north bank.
  for (genvar g = 0; g < L; g++) begin : g_lane
    localparam bit SIDE = (g >= X);
    localparam int LI   = SIDE ? (g - X) : g;
    localparam int D    = LI + 1;
    localparam logic [LW-1:0] LIDX = LI[LW-1:0];

    logic [DW-1:0] r_mem [N];
    logic [PW-1:0] r_rp;
    logic [PW-1:0] r_wp;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [DW-1:0] r_d [D];
    logic [D-1:0]  r_v;
    logic          w_pop;
    logic          w_sel;
    logic          w_rd;
    logic          w_wr;

    assign w_pop = SIDE ? i_northin_rd_en : i_westin_rd_en;
    assign w_sel = i_wr_en && (i_wr_side == SIDE) && (i_wr_lane == LIDX);
    assign w_rd  = w_pop && (r_cnt != '0);
    // A full lane still accepts a write when it is popped in the same cycle.
    assign w_wr  = w_sel && ((r_cnt != NFULL) || w_pop);
    assign w_ovf[g] = w_sel && (r_cnt == NFULL) && !w_pop;
    assign w_udf[g] = w_pop && (r_cnt == '0);

    always_comb begin
      w_cnt_nxt = r_cnt;
      if (w_wr && !w_rd)
        w_cnt_nxt = r_cnt + CW'(1);
      else if (w_rd && !w_wr)
        w_cnt_nxt = r_cnt - CW'(1);
    end
    assign w_full_nxt[g] = (w_cnt_nxt == NFULL);

    always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        r_rp  <= '0;
        r_wp  <= '0;
        r_cnt <= '0;
      end else if (i_clear) begin
        r_rp  <= '0;
        r_wp  <= '0;
        r_cnt <= '0;
      end else begin
        if (w_rd) r_rp <= (r_rp == PMAX) ? '0 : r_rp + PW'(1);
        if (w_wr) r_wp <= (r_wp == PMAX) ? '0 : r_wp + PW'(1);
        r_cnt <= w_cnt_nxt;
      end
    end

    always_ff @(posedge clk) begin
      if (w_wr && !i_clear) r_mem[r_wp] <= i_wr_data;
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        for (int k = 0; k < D; k++) r_d[k] <= '0;
        r_v <= '0;
      end else if (i_clear) begin
        for (int k = 0; k < D; k++) r_d[k] <= '0;
        r_v <= '0;
      end else begin
        r_d[0] <= w_rd ? r_mem[r_rp] : '0;
        r_v[0] <= w_rd;
        for (int k = 1; k < D; k++) begin
          r_d[k] <= r_d[k-1];
          r_v[k] <= r_v[k-1];
        end
      end
    end

    if (!SIDE) begin : g_west
      assign o_west_data[LI*DW +: DW] = r_d[D-1];
      assign o_west_vld[LI]           = r_v[D-1];
    end else begin : g_north
      assign o_north_data[LI*DW +: DW] = r_d[D-1];
      assign o_north_vld[LI]           = r_v[D-1];
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_ready   <= 1'b0;
      r_err_ovf <= 1'b0;
      r_err_udf <= 1'b0;
    end else if (i_clear) begin
      r_ready   <= 1'b0;
      r_err_ovf <= 1'b0;
      r_err_udf <= 1'b0;
    end else begin
      r_ready   <= &w_full_nxt;
      r_err_ovf <= r_err_ovf | (|w_ovf) | w_oor;
      r_err_udf <= r_err_udf | (|w_udf);
    end
  end

  assign o_ready   = r_ready;
  assign o_err_ovf = r_err_ovf;
  assign o_err_udf = r_err_udf;
endmodule

// File: tb/tb_sa_input_feeder.sv
// Directed + random bench for sa_input_feeder against a queue-based reference model.
module tb_sa_input_feeder;
  localparam int X = 3, N = 4, Y = 3, DW = 16, LW = 2, L = X + Y, HMAX = 4096;

  logic            clk = 1'b0;
  logic            sys_rst_n = 1'b0;
  logic            clear = 1'b0;
  logic            wr_en = 1'b0;
  logic            wr_side = 1'b0;
  logic [LW-1:0]   wr_lane = '0;
  logic [DW-1:0]   wr_data = '0;
  logic            westin_rd_en = 1'b0;
  logic            northin_rd_en = 1'b0;
  logic [X*DW-1:0] west_data;
  logic [X-1:0]    west_vld;
  logic [Y*DW-1:0] north_data;
  logic [Y-1:0]    north_vld;
  logic            ready, err_ovf, err_udf;

  sa_input_feeder #(.X(X), .N(N), .Y(Y), .DW(DW)) dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .i_clear(clear),
    .i_wr_en(wr_en), .i_wr_side(wr_side), .i_wr_lane(wr_lane), .i_wr_data(wr_data),
    .i_westin_rd_en(westin_rd_en), .i_northin_rd_en(northin_rd_en),
    .o_west_data(west_data), .o_west_vld(west_vld),
    .o_north_data(north_data), .o_north_vld(north_vld),
    .o_ready(ready), .o_err_ovf(err_ovf), .o_err_udf(err_udf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: one queue per lane; the skew is "lane i shows what its head gave i edges ago".
  typedef logic [DW-1:0] word_q_t [$];
  word_q_t       mq [L];
  logic [DW-1:0] hist_d [L][HMAX];
  bit            hist_v [L][HMAX];
  int            tcur = 0;
  int            base = 1;
  bit            m_ovf = 0, m_udf = 0, m_ready = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, tcur, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int l = 0; l < L; l++) mq[l].delete();
    m_ovf = 0; m_udf = 0; m_ready = 0;
    base = tcur + 1;
  endfunction

  function automatic void model_edge(bit we, bit ws, int wl, logic [DW-1:0] wd, bit pw, bit pn, bit clr);
    tcur++;
    if (clr) begin
      for (int l = 0; l < L; l++) begin
        mq[l].delete();
        hist_d[l][tcur] = '0;
        hist_v[l][tcur] = 0;
      end
      m_ovf = 0; m_udf = 0; m_ready = 0;
      base = tcur;
      return;
    end
    for (int l = 0; l < L; l++) begin
      bit pop = (l < X) ? pw : pn;
      hist_d[l][tcur] = '0;
      hist_v[l][tcur] = 0;
      if (pop) begin
        if (mq[l].size() == 0) m_udf = 1;
        else begin
          hist_d[l][tcur] = mq[l].pop_front();
          hist_v[l][tcur] = 1;
        end
      end
    end
    if (we) begin
      int lim = ws ? Y : X;
      if (wl >= lim) m_ovf = 1;
      else begin
        int li = ws ? X + wl : wl;
        if (mq[li].size() == N) m_ovf = 1;
        else mq[li].push_back(wd);
      end
    end
    m_ready = 1;
    for (int l = 0; l < L; l++) if (mq[l].size() != N) m_ready = 0;
  endfunction

  task automatic check_outputs();
    for (int l = 0; l < L; l++) begin
      int li = (l < X) ? l : l - X;
      int k = tcur - li;
      logic [DW-1:0] ed = '0;
      logic ev = 1'b0;
      logic [DW-1:0] od;
      logic ov;
      if (k >= base && k >= 1) begin
        ed = hist_d[l][k];
        ev = hist_v[l][k];
      end
      od = (l < X) ? west_data[li*DW +: DW] : north_data[li*DW +: DW];
      ov = (l < X) ? west_vld[li] : north_vld[li];
      chk($sformatf("data_lane%0d", l), 64'(od), 64'(ed));
      chk($sformatf("vld_lane%0d", l), 64'(ov), 64'(ev));
    end
    chk("ready", 64'(ready), 64'(m_ready));
    chk("err_ovf", 64'(err_ovf), 64'(m_ovf));
    chk("err_udf", 64'(err_udf), 64'(m_udf));
  endtask

  task automatic cyc(input bit we, input bit ws, input int wl, input int wd,
                     input bit pw, input bit pn, input bit clr);
    wr_en = we; wr_side = ws; wr_lane = wl[LW-1:0]; wr_data = wd[DW-1:0];
    westin_rd_en = pw; northin_rd_en = pn; clear = clr;
    @(posedge clk);
    model_edge(we, ws, wl, wd[DW-1:0], pw, pn, clr);
    #1;
    check_outputs();
    wr_en = 0; wr_side = 0; wr_lane = '0; wr_data = '0;
    westin_rd_en = 0; northin_rd_en = 0; clear = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_wdata"}, 64'(west_data), 64'd0);
    chk({tag, "_wvld"},  64'(west_vld), 64'd0);
    chk({tag, "_ndata"}, 64'(north_data), 64'd0);
    chk({tag, "_nvld"},  64'(north_vld), 64'd0);
    chk({tag, "_ready"}, 64'(ready), 64'd0);
    chk({tag, "_ovf"},   64'(err_ovf), 64'd0);
    chk({tag, "_udf"},   64'(err_udf), 64'd0);
  endtask

  task automatic load_all(input int woff, input int noff);
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < N; k++) begin
        cyc(1, 0, r, woff + 10*r + k, 0, 0, 0);
        cyc(1, 1, r, noff + 10*r + k, 0, 0, 0);
      end
  endtask

  initial begin
    #12;
    check_all_zero("reset");
    @(negedge clk);
    sys_rst_n = 1'b1;
    model_reset();
    idle(2);

    // Full load then streamed pops
    load_all(0, 100);
    idle(1);
    chk("ready_loaded", 64'(ready), 64'd1);
    for (int i = 0; i < N; i++) cyc(0, 0, 0, 0, 1, 1, 0);
    chk("ready_after_pops", 64'(ready), 64'd0);
    idle(6);

    // Single pop skew pattern
    for (int r = 0; r < 3; r++) cyc(1, 0, r, 50 + r, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("skew_001", 64'(west_vld), 64'b001);
    idle(1);
    chk("skew_010", 64'(west_vld), 64'b010);
    idle(1);
    chk("skew_100", 64'(west_vld), 64'b100);
    idle(1);
    chk("skew_000", 64'(west_vld), 64'b000);

    // Overflow on a full lane, then drain it past empty
    cyc(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(1, 0, 1, 300 + i, 0, 0, 0);
    chk("ovf_full", 64'(err_ovf), 64'd1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1, 0, 0);
    idle(3);

    // Out-of-range north lane
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(1, 1, 3, 77, 0, 0, 0);
    chk("ovf_range", 64'(err_ovf), 64'd1);

    // Underflow with west lane 2 empty
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 400, 0, 0, 0);
    cyc(1, 0, 1, 410, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    idle(3);
    chk("udf_lane2", 64'(err_udf), 64'd1);

    // Write and pop the same full lane across pointer wrap
    cyc(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < N; i++) cyc(1, 0, 0, 200 + i, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 210 + i, 1, 0, 0);
    for (int i = 0; i < N + 1; i++) cyc(0, 0, 0, 0, 1, 0, 0);
    idle(3);

    // Asynchronous reset mid-stream
    cyc(0, 0, 0, 0, 0, 0, 1);
    load_all(1000, 2000);
    cyc(0, 0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 1, 1, 0);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check_all_zero("arst");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    sys_rst_n = 1'b1;
    model_reset();
    load_all(3000, 4000);
    idle(1);
    chk("ready_reload", 64'(ready), 64'd1);
    for (int i = 0; i < N; i++) cyc(0, 0, 0, 0, 1, 1, 0);
    idle(6);

    // clear wipes sticky flags
    cyc(1, 1, 3, 5, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("flags_set", 64'({err_ovf, err_udf}), 64'b11);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("flags_cleared", 64'({err_ovf, err_udf}), 64'b00);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      bit we  = ($urandom_range(0, 1) == 1);
      bit ws  = ($urandom_range(0, 1) == 1);
      int wl  = $urandom_range(0, 3);
      int wd  = $urandom_range(0, 65535);
      bit pw  = ($urandom_range(0, 3) == 0);
      bit pn  = ($urandom_range(0, 3) == 0);
      bit clr = ($urandom_range(0, 63) == 0);
      cyc(we, ws, wl, wd, pw, pn, clr);
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
